rtc_timekeeper: RTL
===================

# rtc_timekeeper

- Consumes the one-clock-wide 1 Hz tick pulse from the clock divider.
- Keeps time of day as packed BCD seconds, minutes and hours in 24-hour format.
- Accepts load requests from the host over a valid/ready handshake; values are range-checked before they are committed.
- Sits directly downstream of the divider in the RTC datapath, with its outputs feeding the display/readout logic.

## Interface

Parameters:
- RESET_HOUR, 8'h00, BCD hour loaded on reset; must be valid BCD, 00-23.
- RESET_MIN, 8'h00, BCD minute loaded on reset; must be valid BCD, 00-59.
- RESET_SEC, 8'h00, BCD second loaded on reset; must be valid BCD, 00-59.

Ports:
- clk  in  1  system clock; one clock domain.
- rst_n  in  1  reset, asynchronous assert, active-low.
- tick  in  1  1 Hz pulse from the divider, exactly one clk wide.
- set_valid  in  1  host load request; held high until accepted.
- set_ready  out  1  block can accept a load this cycle.
- set_hour  in  8  BCD hour to load; must stay stable while set_valid is high.
- set_min  in  8  BCD minute to load; same stability rule.
- set_sec  in  8  BCD second to load; same stability rule.
- set_err  out  1  one-cycle pulse: load rejected because a value is out of range.
- hour  out  8  current BCD hour.
- min  out  8  current BCD minute.
- sec  out  8  current BCD second.
- sec_pulse  out  1  one-cycle pulse on the cycle the time advances.
- day_pulse  out  1  one-cycle pulse on the 23:59:59 -> 00:00:00 wrap.

## Operation

**Reset values**
- hour/min/sec = RESET_HOUR / RESET_MIN / RESET_SEC.
- set_ready = 1.
- set_err, sec_pulse, day_pulse = 0.

**Counting**
- Each BCD field is a ones digit (0-9) plus a tens digit.
- Tens limits: sec 0-5, min 0-5, hour 0-2; when hour tens = 2, hour ones is limited to 0-3.
- On tick, sec increments. Carry ripples combinationally within the same cycle: sec 59 -> 00 increments min; min 59 -> 00 increments hour; hour 23 -> 00 asserts day_pulse.

**Load FSM: IDLE -> CHECK -> IDLE**
- IDLE: set_ready = 1. On set_valid && set_ready, capture set_* into a holding register and go to CHECK.
- CHECK: set_ready = 0 for exactly one cycle.
  - A field is out of range if any nibble > 9, any tens digit exceeds its limit, or hour > 23.
  - Any out-of-range field: pulse set_err, leave time unchanged.
  - All fields valid: commit the held values.
  - Either way, return to IDLE.

**Arbitration**
- A commit in CHECK overrides a tick in the same cycle. That tick is discarded and sec_pulse stays 0, so the loaded time stands exactly.
- A tick during the IDLE capture cycle is processed normally; the commit in the next cycle then overwrites the result.
- Reset mid-load: the FSM returns to IDLE, the holding register is cleared, and no set_err is issued.

## Timing

- tick at cycle N: updated sec/min/hour are visible at N+1; sec_pulse and day_pulse are high during N+1 only.
- Load: handshake at cycle N; commit or set_err at N+1; new time visible at N+2; set_ready is high again at N+2.
- Maximum one load per 2 cycles.
- Ticks arriving back-to-back on consecutive cycles, which is out of spec for the divider, are still counted, one per cycle.
- All outputs are registered; there is no combinational path from any input to any output.

## Structure

**Shared rtc package**
- BCD range limits: SEC_TENS_MAX = 5, MIN_TENS_MAX = 5, HOUR_TENS_MAX = 2, HOUR_ONES_MAX_AT_2 = 3.
- Load-FSM state encoding: IDLE, CHECK.
- A BCD-validity function used by both the CHECK state and the bench.

**Sub-module `bcd_mod_counter`**
- Parameter LIMIT, in BCD.
- Inputs: inc, load, load_val. Outputs: value, wrap.
- Three instances: sec (LIMIT 8'h59), min (8'h59), hour (8'h23).
- wrap is combinational out of the sub-module and chains into the next instance's inc.

## Test plan

- Reset with defaults, then 61 ticks -> time 00:01:01, sixty-one sec_pulse, no day_pulse.
- Load 23:59:58, then 2 ticks -> 23:59:59, then 00:00:00. day_pulse is high exactly on the second update cycle.
- Load 24:00:00, then 12:60:00, then 12:1A:00 -> set_err pulse for each, time unchanged, set_ready returns at N+2.
- Load 10:20:30 with tick coincident with the CHECK cycle -> time 10:20:30 at N+2, sec_pulse not asserted.
- Hold set_valid through the CHECK cycle -> exactly one capture; a second capture occurs only after set_ready returns.
- Assert rst_n low asynchronously mid-CHECK and mid-count -> outputs return to RESET_* immediately, no set_err, counting resumes on the first tick after release.

Source files
------------

// File: rtl/rtc_timekeeper_pkg.sv
// Shared definitions for the RTC timekeeper: BCD range limits, load-FSM states
// and the BCD time-validity check.
package rtc_timekeeper_pkg;

   localparam logic [3:0] ONES_MAX           = 4'd9;
   localparam logic [3:0] SEC_TENS_MAX       = 4'd5;
   localparam logic [3:0] MIN_TENS_MAX       = 4'd5;
   localparam logic [3:0] HOUR_TENS_MAX      = 4'd2;
   localparam logic [3:0] HOUR_ONES_MAX_AT_2 = 4'd3;

   typedef enum logic {
      IDLE,
      CHECK
   } load_state_e;

   // A field is valid when both digits are decimal, the tens digit is within
   // its limit and, at the top tens value, the ones digit is within its limit.
   function automatic logic bcd_field_ok(input logic [7:0] v,
                                         input logic [3:0] tens_max,
                                         input logic [3:0] ones_max_at_top);
      logic ok;
      ok = (v[3:0] <= ONES_MAX) && (v[7:4] <= tens_max);
      if ((v[7:4] == tens_max) && (v[3:0] > ones_max_at_top)) begin
         ok = 1'b0;
      end
      return ok;
   endfunction

   function automatic logic bcd_time_ok(input logic [7:0] h,
                                        input logic [7:0] m,
                                        input logic [7:0] s);
      return bcd_field_ok(h, HOUR_TENS_MAX, HOUR_ONES_MAX_AT_2) &&
             bcd_field_ok(m, MIN_TENS_MAX, ONES_MAX) &&
             bcd_field_ok(s, SEC_TENS_MAX, ONES_MAX);
   endfunction

endpackage

// File: rtl/rtc_timekeeper_bcd_mod_counter.sv
// Two-digit BCD modulo counter with synchronous load; wrap is combinational so
// carries ripple through a chain of instances within one cycle.
module bcd_mod_counter
   import rtc_timekeeper_pkg::*;
#(
   parameter logic [7:0] LIMIT     = 8'h59,
   parameter logic [7:0] RESET_VAL = 8'h00
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       inc,
   input  logic       load,
   input  logic [7:0] load_val,
   output logic [7:0] value,
   output logic       wrap
);

   logic [7:0] value_q, value_d;

   assign value = value_q;
   assign wrap  = inc && (value_q == LIMIT);

   always_comb begin
      value_d = value_q;
      if (load) begin
         value_d = load_val;
      end else if (inc) begin
         if (value_q == LIMIT) begin
            value_d = '0;
         end else if (value_q[3:0] == ONES_MAX) begin
            value_d = {value_q[7:4] + 4'd1, 4'd0};
         end else begin
            value_d = {value_q[7:4], value_q[3:0] + 4'd1};
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         value_q <= RESET_VAL;
      end else begin
         value_q <= value_d;
      end
   end

endmodule

// File: rtl/rtc_timekeeper.sv
// Time-of-day keeper: BCD hh:mm:ss advanced by the 1 Hz tick, with a
// range-checked host load path (IDLE -> CHECK -> IDLE).
module rtc_timekeeper
   import rtc_timekeeper_pkg::*;
#(
   parameter logic [7:0] RESET_HOUR = 8'h00,
   parameter logic [7:0] RESET_MIN  = 8'h00,
   parameter logic [7:0] RESET_SEC  = 8'h00
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       tick,
   input  logic       set_valid,
   output logic       set_ready,
   input  logic [7:0] set_hour,
   input  logic [7:0] set_min,
   input  logic [7:0] set_sec,
   output logic       set_err,
   output logic [7:0] hour,
   output logic [7:0] min,
   output logic [7:0] sec,
   output logic       sec_pulse,
   output logic       day_pulse
);

   load_state_e state_q, state_d;
   logic [7:0]  hold_hour_q, hold_hour_d;
   logic [7:0]  hold_min_q, hold_min_d;
   logic [7:0]  hold_sec_q, hold_sec_d;
   logic        sec_pulse_q, day_pulse_q;
   logic        hold_ok, commit, sec_inc;
   logic        sec_wrap, min_wrap, hour_wrap;

   // Validity is judged from the holding register, so set_err and commit are
   // decoded purely from state and never see the live inputs.
   assign hold_ok   = bcd_time_ok(hold_hour_q, hold_min_q, hold_sec_q);
   assign commit    = (state_q == CHECK) && hold_ok;
   assign sec_inc   = tick && !commit;
   assign set_ready = (state_q == IDLE);
   assign set_err   = (state_q == CHECK) && !hold_ok;
   assign sec_pulse = sec_pulse_q;
   assign day_pulse = day_pulse_q;

   always_comb begin
      state_d     = state_q;
      hold_hour_d = hold_hour_q;
      hold_min_d  = hold_min_q;
      hold_sec_d  = hold_sec_q;
      case (state_q)
         IDLE: begin
            if (set_valid) begin
               state_d     = CHECK;
               hold_hour_d = set_hour;
               hold_min_d  = set_min;
               hold_sec_d  = set_sec;
            end
         end
         CHECK: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         hold_hour_q <= '0;
         hold_min_q  <= '0;
         hold_sec_q  <= '0;
         sec_pulse_q <= 1'b0;
         day_pulse_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         hold_hour_q <= hold_hour_d;
         hold_min_q  <= hold_min_d;
         hold_sec_q  <= hold_sec_d;
         sec_pulse_q <= sec_inc;
         day_pulse_q <= hour_wrap;
      end
   end

   bcd_mod_counter #(.LIMIT(8'h59), .RESET_VAL(RESET_SEC)) u_sec (
      .clk(clk), .rst_n(rst_n), .inc(sec_inc), .load(commit),
      .load_val(hold_sec_q), .value(sec), .wrap(sec_wrap)
   );

   bcd_mod_counter #(.LIMIT(8'h59), .RESET_VAL(RESET_MIN)) u_min (
      .clk(clk), .rst_n(rst_n), .inc(sec_wrap), .load(commit),
      .load_val(hold_min_q), .value(min), .wrap(min_wrap)
   );

   bcd_mod_counter #(.LIMIT(8'h23), .RESET_VAL(RESET_HOUR)) u_hour (
      .clk(clk), .rst_n(rst_n), .inc(min_wrap), .load(commit),
      .load_val(hold_hour_q), .value(hour), .wrap(hour_wrap)
   );

endmodule
